// File: rtl/sum_arbiter_pkg.sv
// Shared types, constants and helpers for the shared-adder arbiter.
package sum_arbiter_pkg;

    localparam int SUM_W   = 16;   // default operand/result width of the shared adder
    localparam int MAX_REQ = 8;    // largest supported requester count
    localparam int IDX_W   = 3;    // index width able to address MAX_REQ requesters

    // First set request bit searching ptr, ptr+1, ... wrapping at n.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        logic [IDX_W-1:0] sel;
        logic             found;
        int               k;
        sel   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= n) begin
                k = k - n;
            end else begin
                k = k;
            end
            if ((i < n) && !found && req[k[IDX_W-1:0]]) begin
                sel   = k[IDX_W-1:0];
                found = 1'b1;
            end else begin
                sel   = sel;
                found = found;
            end
        end
        return sel;
    endfunction

    // Index of the set bit of a one-hot vector (0 when empty).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sum_arbiter_if.sv
// Requester-side bus of the shared-adder arbiter.
interface sum_arbiter_if
    import sum_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int W       = SUM_W
);
    logic [NUM_REQ-1:0]   req_i;
    logic [NUM_REQ-1:0]   lock_i;
    logic [NUM_REQ*W-1:0] a_i;
    logic [NUM_REQ*W-1:0] b_i;
    logic [NUM_REQ-1:0]   gnt_o;
    logic [W-1:0]         res_o;
    logic [NUM_REQ-1:0]   res_valid_o;
    logic                 busy;

    modport master (
        output req_i, lock_i, a_i, b_i,
        input  gnt_o, res_o, res_valid_o, busy
    );

    modport slave (
        input  req_i, lock_i, a_i, b_i,
        output gnt_o, res_o, res_valid_o, busy
    );
endinterface

// File: rtl/sum_arbiter_rr_arbiter.sv
// Round-robin arbiter with grant locking; reusable for any shared resource.
module rr_arbiter
    import sum_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_lock,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_lock_valid,
    input  logic [IDX_W-1:0]   i_lock_idx,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_locked
);
    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_lock_ext;
    logic [MAX_REQ-1:0] w_gnt_ext;
    logic [IDX_W-1:0]   w_idx;
    logic               w_hold;

    assign w_req_ext  = MAX_REQ'(i_req);
    assign w_lock_ext = MAX_REQ'(i_lock);
    // The holder keeps the grant only while it still requests and still asks for the lock.
    assign w_hold     = i_lock_valid & w_req_ext[i_lock_idx] & w_lock_ext[i_lock_idx];

    // Pick the winner: lock holder first, otherwise round-robin from the pointer.
    always_comb begin
        w_idx     = 3'd0;
        w_gnt_ext = '0;
        if (w_hold) begin
            w_idx = i_lock_idx;
        end else begin
            w_idx = rr_next(w_req_ext, i_ptr, NUM_REQ);
        end
        if (|i_req) begin
            w_gnt_ext = {{(MAX_REQ-1){1'b0}}, 1'b1} << w_idx;
        end else begin
            w_gnt_ext = '0;
        end
    end

    assign o_gnt    = w_gnt_ext[NUM_REQ-1:0];
    assign o_locked = w_hold;

endmodule

// File: rtl/sum_arbiter.sv
// Shares one external W-bit adder between NUM_REQ requesters, one add per cycle.
module sum_arbiter
    import sum_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int W       = SUM_W
) (
    input  logic         clk,
    input  logic         rst,
    sum_arbiter_if.slave bus,
    output logic [W-1:0] sum_in_a,
    output logic [W-1:0] sum_in_b,
    input  logic [W-1:0] sum_out
);
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_lock_valid;
    logic [IDX_W-1:0]   r_lock_idx;
    logic [W-1:0]       r_res;
    logic [NUM_REQ-1:0] r_res_valid;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_locked;
    logic               w_gnt_any;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_ptr_inc;
    logic [MAX_REQ-1:0] w_lock_ext;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req        (bus.req_i),
        .i_lock       (bus.lock_i),
        .i_ptr        (r_rr_ptr),
        .i_lock_valid (r_lock_valid),
        .i_lock_idx   (r_lock_idx),
        .o_gnt        (w_gnt),
        .o_locked     (w_locked)
    );

    assign w_gnt_any  = |w_gnt;
    assign w_gnt_idx  = onehot_to_idx(MAX_REQ'(w_gnt));
    assign w_lock_ext = MAX_REQ'(bus.lock_i);

    // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
    always_comb begin
        w_ptr_inc = 3'd0;
        if (w_gnt_idx == IDX_W'(NUM_REQ - 1)) begin
            w_ptr_inc = 3'd0;
        end else begin
            w_ptr_inc = w_gnt_idx + 3'd1;
        end
    end

    // One-hot AND-OR operand mux; zero operands when nobody is granted.
    always_comb begin
        sum_in_a = '0;
        sum_in_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                sum_in_a = sum_in_a | bus.a_i[k*W +: W];
                sum_in_b = sum_in_b | bus.b_i[k*W +: W];
            end else begin
                sum_in_a = sum_in_a;
                sum_in_b = sum_in_b;
            end
        end
    end

    // Capture the granted sum, pulse its owner, and advance pointer/lock state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr     <= 3'd0;
            r_lock_valid <= 1'b0;
            r_lock_idx   <= 3'd0;
            r_res        <= '0;
            r_res_valid  <= '0;
        end else if (w_gnt_any) begin
            r_res        <= sum_out;
            r_res_valid  <= w_gnt;
            r_lock_valid <= w_lock_ext[w_gnt_idx];
            r_lock_idx   <= w_gnt_idx;
            if (!w_locked) begin
                r_rr_ptr <= w_ptr_inc;
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end else begin
            r_res_valid  <= '0;
            r_lock_valid <= 1'b0;
        end
    end

    assign bus.gnt_o       = w_gnt;
    assign bus.res_o       = r_res;
    assign bus.res_valid_o = r_res_valid;
    assign bus.busy        = (|bus.req_i) | (|r_res_valid);

endmodule

// File: tb/tb_sum_arbiter.sv
// Self-checking bench for sum_arbiter: directed vectors plus a per-cycle model compare.
module tb_sum_arbiter;
    localparam int N = 2;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sum_in_a;
    logic [W-1:0] sum_in_b;
    logic [W-1:0] sum_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: what the arbiter must hold after each clock edge.
    int           m_ptr      = 0;
    bit           m_lock_v   = 1'b0;
    int           m_lock_idx = 0;
    logic [W-1:0] m_res      = '0;
    logic [N-1:0] m_valid    = '0;

    // System test: two iterative cube-root units.
    int           sx   [N];
    int           sy   [N];
    int           sc   [N];
    int           sd   [N];
    int           se   [N];
    int           sph  [N];
    bit           sdone[N];
    bit           sinf [N];
    logic [N-1:0] sreq;
    logic [W-1:0] soa  [N];
    logic [W-1:0] sob  [N];
    bit           all_done;
    int           cyc_cnt;

    sum_arbiter_if #(.NUM_REQ(N), .W(W)) bus ();

    sum_arbiter #(.NUM_REQ(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sum_in_a (sum_in_a),
        .sum_in_b (sum_in_b),
        .sum_out  (sum_out)
    );

    // The shared adder that lives beside the arbiter.
    assign sum_out = sum_in_a + sum_in_b;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs shortly after the posedge; returns with outputs settled.
    task automatic cyc(input logic r, input logic [N-1:0] req, input logic [N-1:0] lock,
                       input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1);
        @(posedge clk);
        #2;
        rst        = r;
        bus.req_i  = req;
        bus.lock_i = lock;
        bus.a_i    = {a1, a0};
        bus.b_i    = {b1, b0};
        #1;
    endtask

    // Winner by the rules: live lock holder first, else first requester from the pointer.
    function automatic int model_grant(output bit locked);
        locked = 1'b0;
        if (m_lock_v && bus.req_i[m_lock_idx] && bus.lock_i[m_lock_idx]) begin
            locked = 1'b1;
            return m_lock_idx;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.req_i[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    // Per-cycle compare against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        int           g;
        bit           lk;
        logic [N-1:0] eg;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        if (chk_en) begin
            g = model_grant(lk);
            if (g >= 0) begin
                eg = N'(1) << g;
                ea = W'(bus.a_i >> (g*W));
                eb = W'(bus.b_i >> (g*W));
            end else begin
                eg = '0;
                ea = '0;
                eb = '0;
            end
            check("mdl_gnt",   32'(bus.gnt_o),       32'(eg));
            check("mdl_sum_a", 32'(sum_in_a),        32'(ea));
            check("mdl_sum_b", 32'(sum_in_b),        32'(eb));
            check("mdl_res",   32'(bus.res_o),       32'(m_res));
            check("mdl_valid", 32'(bus.res_valid_o), 32'(m_valid));
            check("mdl_busy",  32'(bus.busy),        32'((|bus.req_i) || (|m_valid)));
            if (!rst) begin
                m_ptr = 0; m_lock_v = 1'b0; m_lock_idx = 0; m_res = '0; m_valid = '0;
            end else if (g >= 0) begin
                m_res      = ea + eb;
                m_valid    = eg;
                m_lock_v   = bus.lock_i[g];
                m_lock_idx = g;
                if (!lk) m_ptr = (g + 1) % N;
            end else begin
                m_valid  = '0;
                m_lock_v = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b0; bus.req_i = '0; bus.lock_i = '0; bus.a_i = '0; bus.b_i = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        cyc(1'b0, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
        check("reset_res",   32'(bus.res_o),       32'd0);
        check("reset_valid", 32'(bus.res_valid_o), 32'd0);
        check("reset_busy",  32'(bus.busy),        32'd0);
        cyc(1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);

        // Contention, pointer at 0: 01,10,01,10.
        cyc(1'b1, 2'b11, 2'b00, 16'd1, 16'd2, 16'd10, 16'd20);
        check("cont_gnt0", 32'(bus.gnt_o), 32'h1);
        check("cont_val0", 32'(bus.res_valid_o), 32'h0);
        cyc(1'b1, 2'b11, 2'b00, 16'd1, 16'd2, 16'd10, 16'd20);
        check("cont_gnt1", 32'(bus.gnt_o), 32'h2);
        check("cont_val1", 32'(bus.res_valid_o), 32'h1);
        check("cont_res1", 32'(bus.res_o), 32'd3);
        cyc(1'b1, 2'b11, 2'b00, 16'd1, 16'd2, 16'd10, 16'd20);
        check("cont_gnt2", 32'(bus.gnt_o), 32'h1);
        check("cont_res2", 32'(bus.res_o), 32'd30);
        cyc(1'b1, 2'b11, 2'b00, 16'd1, 16'd2, 16'd10, 16'd20);
        check("cont_gnt3", 32'(bus.gnt_o), 32'h2);
        cyc(1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
        check("cont_val4", 32'(bus.res_valid_o), 32'h2);
        check("cont_res4", 32'(bus.res_o), 32'd30);

        // Single request.
        cyc(1'b1, 2'b01, 2'b00, 16'd27, 16'd37, 16'd0, 16'd0);
        check("single_gnt", 32'(bus.gnt_o), 32'h1);
        cyc(1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
        check("single_res",   32'(bus.res_o), 32'd64);
        check("single_valid", 32'(bus.res_valid_o), 32'h1);
        check("single_busy",  32'(bus.busy), 32'd1);

        // Bring the pointer back to 0, then lock requester 0 for three cycles.
        cyc(1'b1, 2'b10, 2'b00, 16'd0, 16'd0, 16'd4, 16'd4);
        check("ptr_gnt", 32'(bus.gnt_o), 32'h2);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b11, 2'b01, 16'd100, 16'd1, 16'd200, 16'd2);
            check("lock_gnt", 32'(bus.gnt_o), 32'h1);
        end
        cyc(1'b1, 2'b11, 2'b00, 16'd100, 16'd1, 16'd200, 16'd2);
        check("unlock_gnt", 32'(bus.gnt_o), 32'h2);
        check("lock_res",   32'(bus.res_o), 32'd101);
        cyc(1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
        check("unlock_res", 32'(bus.res_o), 32'd202);

        // Modular wrap.
        cyc(1'b1, 2'b10, 2'b00, 16'd0, 16'd0, 16'hFFFF, 16'h0001);
        cyc(1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
        check("wrap_res",   32'(bus.res_o), 32'h0);
        check("wrap_valid", 32'(bus.res_valid_o), 32'h2);

        // Reset in the middle of an operation.
        cyc(1'b1, 2'b01, 2'b00, 16'd5, 16'd6, 16'd0, 16'd0);
        cyc(1'b0, 2'b01, 2'b00, 16'd7, 16'd8, 16'd0, 16'd0);
        check("rstop_gnt", 32'(bus.gnt_o), 32'h1);
        check("rstop_res_before", 32'(bus.res_o), 32'd11);
        cyc(1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
        check("rstop_res",   32'(bus.res_o), 32'd0);
        check("rstop_valid", 32'(bus.res_valid_o), 32'h0);
        cyc(1'b1, 2'b11, 2'b00, 16'd1, 16'd1, 16'd2, 16'd2);
        check("rstop_ptr", 32'(bus.gnt_o), 32'h1);
        cyc(1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);

        // System: two cube-root units, each stepping (c,d,e) -> (c+d, d+e, e+6) through the arbiter.
        sx[0] = 27; sx[1] = 216;
        for (int k = 0; k < N; k++) begin
            sy[k] = 0; sc[k] = 0; sd[k] = 1; se[k] = 6; sph[k] = 0; sdone[k] = 1'b0; sinf[k] = 1'b0;
        end
        all_done = 1'b0;
        cyc_cnt  = 0;
        while (!all_done && cyc_cnt < 2000) begin
            @(posedge clk);
            #1;
            cyc_cnt++;
            for (int k = 0; k < N; k++) begin
                if (sinf[k] && bus.res_valid_o[k]) begin
                    if (sph[k] == 0)      sc[k] = int'(bus.res_o);
                    else if (sph[k] == 1) sd[k] = int'(bus.res_o);
                    else begin se[k] = int'(bus.res_o); sy[k]++; end
                    sph[k]  = (sph[k] + 1) % 3;
                    sinf[k] = 1'b0;
                end
                if (!sdone[k] && !sinf[k] && sph[k] == 0 && (sc[k] + sd[k] > sx[k])) sdone[k] = 1'b1;
                sreq[k] = !sdone[k] && !sinf[k];
                if (sph[k] == 0)      begin soa[k] = W'(sc[k]); sob[k] = W'(sd[k]); end
                else if (sph[k] == 1) begin soa[k] = W'(sd[k]); sob[k] = W'(se[k]); end
                else                  begin soa[k] = W'(se[k]); sob[k] = 16'd6;     end
            end
            #1;
            rst        = 1'b1;
            bus.req_i  = sreq;
            bus.lock_i = '0;
            bus.a_i    = {soa[1], soa[0]};
            bus.b_i    = {sob[1], sob[0]};
            #1;
            for (int k = 0; k < N; k++) begin
                if (sreq[k] && bus.gnt_o[k]) sinf[k] = 1'b1;
            end
            all_done = sdone[0] && sdone[1] && !sinf[0] && !sinf[1];
        end
        check("sys_no_timeout", 32'(all_done), 32'd1);
        check("sys_cbrt27",  32'(sy[0]), 32'd3);
        check("sys_cbrt216", 32'(sy[1]), 32'd6);
        cyc(1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
        check("sys_busy_drop", 32'(bus.busy), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the run gets stuck somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
